dram_read_assembler: RTL and testbench
======================================

// Module: dram_read_assembler
// PURPOSE
//  Parametrised read-data assembler between the DDR PHY capture stage and the read-response path.
//  Queues issued read commands (burst size) and consumes pre-captured rise/fall DQ beat pairs.
//  Packs each burst into one zero-padded word and returns it on a valid/ready handshake.
//  Flags data arriving with no command pending, and data lost because the response was not taken.
// PARAMETERS
//  DQ_W      8   DQ width per beat (bits)
//  MAX_BEATS 8   max beats per burst; power of 2, >=2; WORD_W = DQ_W*MAX_BEATS
//  CMD_DEPTH 4   pending-command FIFO depth; power of 2, >=2
//  TIMEOUT   64  cycles allowed between command head-of-queue and its first pair (macro only)
// PORTS
//  clk         in   1        system clock, all logic on posedge
//  n_rst       in   1        asynchronous active-low reset
//  cmd_valid   in   1        read issued; push cmd_size when cmd_ready
//  cmd_size    in   SZW      log2(beats), 0..log2(MAX_BEATS); SZW=$clog2(MAX_BEATS)+1
//  cmd_ready   out  1        command FIFO not full
//  dq_valid    in   1        one captured beat pair present this cycle
//  dq_rise     in   DQ_W     even beat (rising DQS)
//  dq_fall     in   DQ_W     odd beat (falling DQS)
//  rd_valid    out  1        assembled word available
//  rd_data     out  WORD_W   assembled word, beat i at [i*DQ_W +: DQ_W]
//  rd_size     out  SZW      cmd_size of the returned burst
//  rd_ready    in   1        consumer accepts word
//  spurious    out  1        1-cycle pulse: dq_valid with command FIFO empty (pair dropped)
//  overflow    out  1        sticky: burst completed while rd_valid && !rd_ready
//  idle        out  1        FIFO empty, no burst in progress, rd_valid low
// BEHAVIOUR
//  Reset: cmd_ready=1, rd_valid=0, rd_data=0, rd_size=0, spurious=0, overflow=0, idle=1; FIFO, counters, FSM cleared.
//  Reset mid-burst discards partial word and all queued commands; no output after release until new cmds.
//  Command FIFO: push on cmd_valid&&cmd_ready; pop when head burst's last pair accepted.
//   Push and pop in the same cycle are both honoured, including when full.
//   cmd_ready = !full (registered occupancy).
//  Pairs per burst P = max(1, (1<<size)/2). size 0: dq_rise only, dq_fall discarded.
//  FSM states:
//   IDLE: FIFO empty. dq_valid -> spurious pulse, stay.
//     FIFO non-empty -> ASSEMBLE, pair counter=0, assembly reg cleared.
//   ASSEMBLE: each dq_valid writes pair k to beats 2k/2k+1 of assembly reg, k++.
//     On pair P-1: pop FIFO, load output reg (bits above (1<<size)*DQ_W zero), set rd_valid next cycle.
//     Then -> ASSEMBLE if FIFO still non-empty after pop, else IDLE.
//     No dq_valid: hold, no timeout unless macro enabled.
//  Latency: rd_valid rises the cycle after the final pair's dq_valid; back-to-back bursts are gap-free.
//  Output reg: rd_valid cleared on rd_valid&&rd_ready unless a new word loads the same cycle (then stays 1).
//   Burst completing while rd_valid&&!rd_ready: held word/size unchanged, new word dropped.
//   That burst's command is still popped; overflow set and held until reset.
//  DQ cannot be back-pressured; dq_valid is never ignored except as stated above.
//  cmd_size > log2(MAX_BEATS) is clamped to log2(MAX_BEATS).
// CONFIGURATION
//  RDATA_TIMEOUT_EN defined:
//   adds output timeout_err (1, sticky) and a counter per head command.
//   Counter starts when ASSEMBLE is entered or a new head is presented, resets on each dq_valid.
//   Reaching TIMEOUT: set timeout_err, pop head cmd, discard partial word, no rd_valid, re-evaluate FSM.
//  Undefined: no port, no counter; ASSEMBLE waits indefinitely.
// TESTING
//  Reset, then cmd size=3, pairs (11,22),(33,44),(55,66),(77,88):
//   -> rd_data=0x8877665544332211 one cycle after 4th pair; rd_size=3.
//  cmd size=0, pair (AB,CD) -> rd_data=0x00000000000000AB; size=1 pair (12,34) -> 0x3412.
//  Pushes 5 cmds with rd_ready=1 and no data -> cmd_ready low after 4th.
//   Then one size-1 pair with 5th cmd_valid held -> push and pop same cycle, 4 cmds remain queued.
//  dq_valid with empty FIFO -> spurious one cycle, no rd_valid, idle stays 1.
//  Two size-1 bursts back-to-back, rd_ready=0 -> first word held, overflow=1 sticky, FIFO empty.
//  RDATA_TIMEOUT_EN, TIMEOUT=64: cmd, 64 idle cycles -> timeout_err=1, cmd dropped, idle=1.
//   Also n_rst pulsed after 2 of 4 pairs -> all outputs at reset values.

Source files
------------

// File: rtl/dram_read_assembler.sv
// Packs DDR read bursts (rise/fall beat pairs) into one zero-padded word per queued read command.
// Optional feature macro: RDATA_TIMEOUT_EN adds a per-head-command data timeout and sticky timeout_err.
module dram_read_assembler #(
   parameter  int DQ_W      = 8,
   parameter  int MAX_BEATS = 8,
   parameter  int CMD_DEPTH = 4,
   parameter  int TIMEOUT   = 64,
   localparam int SZW       = $clog2(MAX_BEATS) + 1,
   localparam int WORD_W    = DQ_W * MAX_BEATS
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              cmd_valid,
   input  logic [SZW-1:0]    cmd_size,
   output logic              cmd_ready,
   input  logic              dq_valid,
   input  logic [DQ_W-1:0]   dq_rise,
   input  logic [DQ_W-1:0]   dq_fall,
   output logic              rd_valid,
   output logic [WORD_W-1:0] rd_data,
   output logic [SZW-1:0]    rd_size,
   input  logic              rd_ready,
   output logic              spurious,
   output logic              overflow,
   output logic              idle,
`ifdef RDATA_TIMEOUT_EN
   output logic              timeout_err,
`endif
   output logic              o_dbg_state
);

   localparam int LOG_MB = $clog2(MAX_BEATS);
   localparam int AW     = $clog2(CMD_DEPTH);
   localparam int PCW    = $clog2(MAX_BEATS);

   typedef enum logic {S_IDLE = 1'b0, S_ASSEMBLE = 1'b1} state_t;

   // Handshakes: a command transfers when cmd_valid && (cmd_ready || a pop happens this cycle);
   // a word transfers when rd_valid && rd_ready; DQ pairs have no back-pressure.

   logic [SZW-1:0]    r_fifo [CMD_DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [AW:0]       r_count;
   state_t            r_state;
   logic [PCW-1:0]    r_pair;
   logic [WORD_W-1:0] r_asm;
   logic [WORD_W-1:0] r_rd_data;
   logic [SZW-1:0]    r_rd_size;
   logic              r_rd_valid;
   logic              r_spurious;
   logic              r_overflow;

   logic              w_full;
   logic              w_empty;
   logic [SZW-1:0]    w_head;
   logic [SZW-1:0]    w_size_clamp;
   logic [PCW-1:0]    w_pairs_m1;
   logic              w_take;
   logic              w_last;
   logic              w_tmo_pop;
   logic              w_pop;
   logic              w_push;
   logic [AW:0]       w_count_next;
   logic [WORD_W-1:0] w_asm_next;
   logic [WORD_W-1:0] w_word;

   assign w_full       = (r_count == (AW+1)'(CMD_DEPTH));
   assign w_empty      = (r_count == '0);
   assign w_head       = r_fifo[r_rptr];
   assign w_size_clamp = (cmd_size > SZW'(LOG_MB)) ? SZW'(LOG_MB) : cmd_size;
   assign w_take       = dq_valid && !w_empty;
   assign w_last       = w_take && (r_pair == w_pairs_m1);
   assign w_pop        = w_last || w_tmo_pop;
   // A full FIFO still accepts a command in the cycle its head retires.
   assign w_push       = cmd_valid && (!w_full || w_pop);
   assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

   always_comb begin
      int n_pairs;
      int n_beats;
      n_beats    = 1 << int'(w_head);
      n_pairs    = (w_head == '0) ? 1 : (n_beats / 2);
      w_pairs_m1 = PCW'(n_pairs - 1);
      w_asm_next = r_asm;
      w_word     = '0;
      for (int b = 0; b < MAX_BEATS; b++) begin
         if (b == 2 * int'(r_pair))     w_asm_next[b*DQ_W +: DQ_W] = dq_rise;
         if (b == 2 * int'(r_pair) + 1) w_asm_next[b*DQ_W +: DQ_W] = dq_fall;
      end
      for (int b = 0; b < MAX_BEATS; b++) begin
         if (b < n_beats) w_word[b*DQ_W +: DQ_W] = w_asm_next[b*DQ_W +: DQ_W];
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wptr] <= w_size_clamp;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_state    <= S_IDLE;
         r_pair     <= '0;
         r_asm      <= '0;
         r_rd_data  <= '0;
         r_rd_size  <= '0;
         r_rd_valid <= 1'b0;
         r_spurious <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_spurious <= dq_valid && w_empty;
         r_state    <= (w_count_next != '0) ? S_ASSEMBLE : S_IDLE;
         r_count    <= w_count_next;
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;

         if (w_pop) begin
            r_pair <= '0;
            r_asm  <= '0;
         end else if (w_take) begin
            r_pair <= r_pair + 1'b1;
            r_asm  <= w_asm_next;
         end

         // A completed burst only loads when the output slot is free or being emptied now.
         if (w_last) begin
            if (r_rd_valid && !rd_ready) begin
               r_overflow <= 1'b1;
            end else begin
               r_rd_valid <= 1'b1;
               r_rd_data  <= w_word;
               r_rd_size  <= w_head;
            end
         end else if (r_rd_valid && rd_ready) begin
            r_rd_valid <= 1'b0;
         end
      end
   end

`ifdef RDATA_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] r_tmo;
   logic          r_timeout_err;

   assign w_tmo_pop   = !w_empty && !dq_valid && (r_tmo == TW'(TIMEOUT - 1));
   assign timeout_err = r_timeout_err;

   // Counts cycles the current head command has waited without a pair.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_tmo         <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (w_empty || dq_valid || w_tmo_pop) r_tmo <= '0;
         else                                  r_tmo <= r_tmo + 1'b1;
         if (w_tmo_pop) r_timeout_err <= 1'b1;
      end
   end
`else
   assign w_tmo_pop = 1'b0;
`endif

   assign cmd_ready   = !w_full;
   assign rd_valid    = r_rd_valid;
   assign rd_data     = r_rd_data;
   assign rd_size     = r_rd_size;
   assign spurious    = r_spurious;
   assign overflow    = r_overflow;
   assign idle        = w_empty && !r_rd_valid;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dram_read_assembler.sv
// Directed bench for dram_read_assembler: packing, clamping, full FIFO, overflow, spurious, reset.
module tb_dram_read_assembler;
   localparam int DQ_W = 8;
   localparam int MAX_BEATS = 8;
   localparam int SZW = $clog2(MAX_BEATS) + 1;
   localparam int WORD_W = DQ_W * MAX_BEATS;

   logic              clk = 1'b0;
   logic              n_rst = 1'b0;
   logic              cmd_valid = 1'b0;
   logic [SZW-1:0]    cmd_size = '0;
   logic              cmd_ready;
   logic              dq_valid = 1'b0;
   logic [DQ_W-1:0]   dq_rise = '0;
   logic [DQ_W-1:0]   dq_fall = '0;
   logic              rd_valid;
   logic [WORD_W-1:0] rd_data;
   logic [SZW-1:0]    rd_size;
   logic              rd_ready = 1'b0;
   logic              spurious;
   logic              overflow;
   logic              idle;
   logic              dbg_state;
`ifdef RDATA_TIMEOUT_EN
   logic              timeout_err;
`endif

   int checks = 0;
   int failures = 0;

   dram_read_assembler dut (
      .clk(clk), .n_rst(n_rst),
      .cmd_valid(cmd_valid), .cmd_size(cmd_size), .cmd_ready(cmd_ready),
      .dq_valid(dq_valid), .dq_rise(dq_rise), .dq_fall(dq_fall),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_size(rd_size), .rd_ready(rd_ready),
      .spurious(spurious), .overflow(overflow), .idle(idle),
`ifdef RDATA_TIMEOUT_EN
      .timeout_err(timeout_err),
`endif
      .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [SZW-1:0] sz);
      cmd_valid = 1'b1;
      cmd_size  = sz;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic send_pair(input logic [7:0] r, input logic [7:0] f);
      dq_valid = 1'b1;
      dq_rise  = r;
      dq_fall  = f;
      tick();
      dq_valid = 1'b0;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      tick();
      tick();
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
      checks++; if (rd_data !== 64'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
      checks++; if (rd_size !== 4'd0) begin failures++; $display("FAIL reset_rd_size got=%0d exp=0", rd_size); end
      checks++; if (spurious !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", spurious, overflow); end
      checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
      checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
      n_rst = 1'b1;
      tick();
   endtask

   task automatic test_burst8();
      push_cmd(4'd3);
      checks++; if (dbg_state !== 1'b1 || idle !== 1'b0) begin failures++; $display("FAIL b8_busy got state=%b idle=%b exp 1 0", dbg_state, idle); end
      send_pair(8'h11, 8'h22);
      send_pair(8'h33, 8'h44);
      send_pair(8'h55, 8'h66);
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL b8_early got=%b exp=0", rd_valid); end
      send_pair(8'h77, 8'h88);
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL b8_valid got=%b exp=1", rd_valid); end
      checks++; if (rd_data !== 64'h8877665544332211) begin failures++; $display("FAIL b8_data got=%h exp=8877665544332211", rd_data); end
      checks++; if (rd_size !== 4'd3) begin failures++; $display("FAIL b8_size got=%0d exp=3", rd_size); end
      tick();
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL b8_hold got=%b exp=1", rd_valid); end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      checks++; if (rd_valid !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL b8_consume got v=%b idle=%b exp 0 1", rd_valid, idle); end
   endtask

   task automatic test_small_sizes();
      rd_ready = 1'b1;
      push_cmd(4'd0);
      send_pair(8'hAB, 8'hCD);
      checks++; if (rd_data !== 64'h00000000000000AB || rd_size !== 4'd0) begin failures++; $display("FAIL sz0 got=%h/%0d exp=ab/0", rd_data, rd_size); end
      push_cmd(4'd1);
      send_pair(8'h12, 8'h34);
      checks++; if (rd_data !== 64'h0000000000003412 || rd_size !== 4'd1) begin failures++; $display("FAIL sz1 got=%h/%0d exp=3412/1", rd_data, rd_size); end
      push_cmd(4'd2);
      send_pair(8'hA1, 8'hA2);
      send_pair(8'hA3, 8'hA4);
      checks++; if (rd_data !== 64'h00000000A4A3A2A1 || rd_size !== 4'd2) begin failures++; $display("FAIL sz2 got=%h/%0d exp=a4a3a2a1/2", rd_data, rd_size); end
      // Oversized request behaves as the maximum burst.
      push_cmd(4'd9);
      for (int i = 0; i < 4; i++) send_pair(8'(8'h40 + 2*i), 8'(8'h41 + 2*i));
      checks++; if (rd_data !== 64'h4746454443424140 || rd_size !== 4'd3) begin failures++; $display("FAIL clamp got=%h/%0d exp=4746454443424140/3", rd_data, rd_size); end
      tick();
      rd_ready = 1'b0;
      checks++; if (idle !== 1'b1) begin failures++; $display("FAIL small_idle got=%b exp=1", idle); end
   endtask

   task automatic test_full_fifo();
      logic [63:0] exp_w;
      rd_ready  = 1'b1;
      cmd_valid = 1'b1;
      cmd_size  = 4'd1;
      for (int i = 0; i < 3; i++) tick();
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL full_3 got=%b exp=1", cmd_ready); end
      tick();
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL full_4 got=%b exp=0", cmd_ready); end
      dq_valid = 1'b1; dq_rise = 8'h11; dq_fall = 8'h22;
      tick();
      dq_valid  = 1'b0;
      cmd_valid = 1'b0;
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL full_pushpop got=%b exp=0", cmd_ready); end
      checks++; if (rd_valid !== 1'b1 || rd_data !== 64'h2211) begin failures++; $display("FAIL full_word got=%b/%h exp=1/2211", rd_valid, rd_data); end
      for (int i = 0; i < 4; i++) begin
         send_pair(8'(8'h50 + i), 8'(8'h60 + i));
         exp_w = {48'h0, 8'(8'h60 + i), 8'(8'h50 + i)};
         checks++; if (rd_valid !== 1'b1 || rd_data !== exp_w) begin failures++; $display("FAIL drain%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data, exp_w); end
      end
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL drain_ready got=%b exp=1", cmd_ready); end
      tick();
      checks++; if (rd_valid !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL drain_idle got v=%b idle=%b exp 0 1", rd_valid, idle); end
      rd_ready = 1'b0;
   endtask

   task automatic test_overflow();
      push_cmd(4'd1);
      push_cmd(4'd1);
      send_pair(8'h01, 8'h02);
      checks++; if (rd_valid !== 1'b1 || rd_data !== 64'h0201 || overflow !== 1'b0) begin failures++; $display("FAIL ovf_first got=%b/%h/%b exp=1/0201/0", rd_valid, rd_data, overflow); end
      send_pair(8'h03, 8'h04);
      checks++; if (rd_data !== 64'h0201 || rd_size !== 4'd1) begin failures++; $display("FAIL ovf_held got=%h/%0d exp=0201/1", rd_data, rd_size); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      checks++; if (rd_valid !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL ovf_empty got v=%b idle=%b exp 0 1", rd_valid, idle); end
      tick();
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
   endtask

   task automatic test_spurious();
      send_pair(8'hEE, 8'hFF);
      checks++; if (spurious !== 1'b1) begin failures++; $display("FAIL spur_pulse got=%b exp=1", spurious); end
      checks++; if (rd_valid !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL spur_quiet got v=%b idle=%b exp 0 1", rd_valid, idle); end
      tick();
      checks++; if (spurious !== 1'b0) begin failures++; $display("FAIL spur_end got=%b exp=0", spurious); end
   endtask

`ifdef RDATA_TIMEOUT_EN
   task automatic test_timeout();
      push_cmd(4'd3);
      for (int i = 0; i < 63; i++) tick();
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b exp=0", timeout_err); end
      tick();
      checks++; if (timeout_err !== 1'b1 || idle !== 1'b1 || rd_valid !== 1'b0) begin failures++; $display("FAIL tmo_fire got err=%b idle=%b v=%b exp 1 1 0", timeout_err, idle, rd_valid); end
   endtask
`endif

   task automatic test_reset_mid_burst();
      push_cmd(4'd3);
      push_cmd(4'd1);
      send_pair(8'h11, 8'h22);
      send_pair(8'h33, 8'h44);
      n_rst = 1'b0;
      #1;
      checks++; if (cmd_ready !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 64'h0 || rd_size !== 4'd0) begin failures++; $display("FAIL rst_mid_out got r=%b v=%b d=%h s=%0d exp 1 0 0 0", cmd_ready, rd_valid, rd_data, rd_size); end
      checks++; if (spurious !== 1'b0 || overflow !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL rst_mid_flags got sp=%b ov=%b idle=%b exp 0 0 1", spurious, overflow, idle); end
`ifdef RDATA_TIMEOUT_EN
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_mid_tmo got=%b exp=0", timeout_err); end
`endif
      tick();
      n_rst = 1'b1;
      tick();
      send_pair(8'h55, 8'h66);
      checks++; if (spurious !== 1'b1 || rd_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_flushed got sp=%b v=%b exp 1 0", spurious, rd_valid); end
      tick();
      tick();
      checks++; if (rd_valid !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL rst_mid_quiet got v=%b idle=%b exp 0 1", rd_valid, idle); end
   endtask

   initial begin
      test_reset();
      test_burst8();
      test_small_sizes();
      test_full_fifo();
      test_overflow();
      test_spurious();
`ifdef RDATA_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
